// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: one requester's request/response channel into the data-memory controller.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port arbiter turning byte/half/word requests into aligned accesses on a 1-cycle memory.
// Define DMEM_CTRL_RR_EN for round-robin arbitration; otherwise port C has fixed priority over D.
module dmem_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  c_if,
  dmem_ctrl_if.slave  d_if,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic              r_grantD;
  logic              r_we;
  logic              r_unsigned;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_anyValid;
  logic              w_pickD;
  logic              w_accept;
  logic              w_selErr;
  logic              w_rspReady;
  logic [ADDR_W-1:0] w_selAddr;
  logic [1:0]        w_selSize;
  logic [31:0]       w_wordAddr;
  logic [31:0]       w_din;
  logic [31:0]       w_loadData;
  logic [31:0]       w_rspData;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_anyValid = c_if.req_valid | d_if.req_valid;

`ifdef DMEM_CTRL_RR_EN
  logic r_lastD;

  // Last-grant starts at D so that C wins the first tie.
  assign w_pickD = d_if.req_valid & (~c_if.req_valid | ~r_lastD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastD <= 1'b1;
    end else if (w_accept) begin
      r_lastD <= w_pickD;
    end
  end
`else
  assign w_pickD = d_if.req_valid & ~c_if.req_valid;
`endif

  assign w_accept  = rst_n & (r_state == IDLE) & w_anyValid;
  assign w_selAddr = w_pickD ? d_if.req_addr : c_if.req_addr;
  assign w_selSize = w_pickD ? d_if.req_size : c_if.req_size;
  assign w_selErr  = (w_selSize == 2'b11)
                   | ((w_selSize == 2'b01) & w_selAddr[0])
                   | ((w_selSize == 2'b10) & (w_selAddr[1:0] != 2'b00))
                   | ({1'b0, w_selAddr} >= ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grantD   <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
    end else if (w_accept) begin
      r_grantD   <= w_pickD;
      r_we       <= w_pickD ? d_if.req_we       : c_if.req_we;
      r_unsigned <= w_pickD ? d_if.req_unsigned : c_if.req_unsigned;
      r_wdata    <= w_pickD ? d_if.req_wdata    : c_if.req_wdata;
      r_err      <= w_selErr;
      r_size     <= w_selSize;
      r_addr     <= w_selAddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  assign w_rspReady = r_grantD ? d_if.rsp_ready : c_if.rsp_ready;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = MEM;
      MEM:     w_nextState = RSP;
      RSP:     if (w_rspReady) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_wordAddr = 32'({r_addr[ADDR_W-1:2], 2'b00});
  assign w_byte     = mem_dout[8*r_addr[1:0] +: 8];
  assign w_half     = r_addr[1] ? mem_dout[31:16] : mem_dout[15:0];

  always_comb begin
    w_be       = 4'b0000;
    w_din      = r_wdata;
    w_loadData = mem_dout;
    case (r_size)
      2'b00: begin
        w_be       = 4'b0001 << r_addr[1:0];
        w_din      = {4{r_wdata[7:0]}};
        w_loadData = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
        w_din      = {2{r_wdata[15:0]}};
        w_loadData = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      2'b10: begin
        w_be = 4'b1111;
      end
      default: begin
        w_be = 4'b0000;
      end
    endcase
  end

  assign w_rspData = (r_we | r_err) ? 32'h0 : w_loadData;

  // Memory-side signals exist only in MEM/RSP so reset and IDLE present an all-zero bus.
  always_comb begin
    c_if.req_ready = 1'b0;
    c_if.rsp_valid = 1'b0;
    c_if.rsp_rdata = 32'h0;
    c_if.rsp_err   = 1'b0;
    d_if.req_ready = 1'b0;
    d_if.rsp_valid = 1'b0;
    d_if.rsp_rdata = 32'h0;
    d_if.rsp_err   = 1'b0;
    mem_addr       = 32'h0;
    mem_din        = 32'h0;
    mem_we         = 4'b0000;
    case (r_state)
      IDLE: begin
        c_if.req_ready = w_accept & ~w_pickD;
        d_if.req_ready = w_accept & w_pickD;
      end
      MEM: begin
        mem_addr = w_wordAddr;
        mem_din  = w_din;
        mem_we   = (r_we & ~r_err) ? w_be : 4'b0000;
      end
      RSP: begin
        mem_addr = w_wordAddr;
        if (r_grantD) begin
          d_if.rsp_valid = 1'b1;
          d_if.rsp_rdata = w_rspData;
          d_if.rsp_err   = r_err;
        end else begin
          c_if.rsp_valid = 1'b1;
          c_if.rsp_rdata = w_rspData;
          c_if.rsp_err   = r_err;
        end
      end
      default: begin
        mem_addr = 32'h0;
      end
    endcase
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven scoreboard bench for dmem_ctrl with a behavioural 1-cycle memory.
module tb_dmem_ctrl;
  localparam logic [31:0] W10 = 32'h80ADBEEF;

  typedef struct {
    logic        portD;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    logic [3:0]  expBe;
  } vec_t;

  typedef struct {
    logic        portD;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wordAddr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;
  logic [31:0] memArray [0:1023];

  int   nChecks;
  int   nFails;
  vec_t vecs[$];
  exp_t sb[$];

  dmem_ctrl_if #(.ADDR_W(32)) cIf ();
  dmem_ctrl_if #(.ADDR_W(32)) dIf ();

  dmem_ctrl #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_if     (cIf),
    .d_if     (dIf),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: byte-enabled write and registered read of the same word.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) memArray[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
    mem_dout <= memArray[mem_addr[11:2]];
  end

  function automatic vec_t mkVec(input logic portD, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input logic [3:0] expBe);
    vec_t v;
    v.portD = portD; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr; v.expBe = expBe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic setReq(input logic portD, input logic v, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (portD) begin
      dIf.req_valid = v; dIf.req_we = we; dIf.req_size = size;
      dIf.req_unsigned = uns; dIf.req_addr = addr; dIf.req_wdata = wdata;
    end else begin
      cIf.req_valid = v; cIf.req_we = we; cIf.req_size = size;
      cIf.req_unsigned = uns; cIf.req_addr = addr; cIf.req_wdata = wdata;
    end
  endtask

  function automatic logic readyOf(input logic portD);
    return portD ? dIf.req_ready : cIf.req_ready;
  endfunction

  function automatic logic rspValidOf(input logic portD);
    return portD ? dIf.rsp_valid : cIf.rsp_valid;
  endfunction

  function automatic logic [31:0] rdataOf(input logic portD);
    return portD ? dIf.rsp_rdata : cIf.rsp_rdata;
  endfunction

  function automatic logic errOf(input logic portD);
    return portD ? dIf.rsp_err : cIf.rsp_err;
  endfunction

  task automatic pulseRspReady(input logic portD);
    if (portD) dIf.rsp_ready = 1'b1; else cIf.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    dIf.rsp_ready = 1'b0;
    cIf.rsp_ready = 1'b0;
  endtask

  // Drive a request, wait for its grant and record the expected response.
  task automatic applyStimulus(input string tag, input vec_t v, output bit ok);
    int n;
    exp_t e;
    setReq(v.portD, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    n = 0;
    @(negedge clk);
    while (!readyOf(v.portD) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".accept"}, {31'h0, readyOf(v.portD)}, 32'h1);
    ok = readyOf(v.portD);
    if (ok) begin
      e.portD = v.portD; e.rdata = v.expRdata; e.err = v.expErr;
      e.be = v.expBe; e.wordAddr = v.addr & 32'hFFFF_FFFC;
      sb.push_back(e);
      @(posedge clk);
    end
    #1;
    setReq(v.portD, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Called right after the accept edge: checks the MEM cycle, then the response two cycles on.
  task automatic checkOutput(input string tag);
    exp_t e;
    int n;
    e = sb.pop_front();
    @(negedge clk);
    check({tag, ".mem_we"}, {28'h0, mem_we}, {28'h0, e.be});
    check({tag, ".mem_addr"}, mem_addr, e.wordAddr);
    @(negedge clk);
    check({tag, ".latency2"}, {31'h0, rspValidOf(e.portD)}, 32'h1);
    n = 0;
    while (!rspValidOf(e.portD) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".rdata"}, rdataOf(e.portD), e.rdata);
    check({tag, ".err"}, {31'h0, errOf(e.portD)}, {31'h0, e.err});
    check({tag, ".other_rsp"}, {31'h0, rspValidOf(~e.portD)}, 32'h0);
    pulseRspReady(e.portD);
  endtask

  task automatic runVec(input string tag, input vec_t v);
    bit ok;
    applyStimulus(tag, v, ok);
    if (ok) checkOutput(tag);
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, ".c_ready"}, {31'h0, cIf.req_ready}, 32'h0);
    check({tag, ".c_rsp_valid"}, {31'h0, cIf.rsp_valid}, 32'h0);
    check({tag, ".c_rdata"}, cIf.rsp_rdata, 32'h0);
    check({tag, ".mem_we"}, {28'h0, mem_we}, 32'h0);
    check({tag, ".mem_addr"}, mem_addr, 32'h0);
    check({tag, ".mem_din"}, mem_din, 32'h0);
  endtask

  initial begin
    logic expG [5];
    logic g;
    int   n;
    bit   ok;
    exp_t e;

    nChecks = 0;
    nFails  = 0;
    for (int i = 0; i < 1024; i++) memArray[i] = 32'h0;
    mem_dout = 32'h0;
    cIf.rsp_ready = 1'b0;
    dIf.rsp_ready = 1'b0;
    setReq(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    setReq(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    rst_n = 1'b0;

    vecs.push_back(mkVec(0, 1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 4'b1111));
    vecs.push_back(mkVec(0, 0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 4'b0000));
    vecs.push_back(mkVec(0, 1, 2'b00, 0, 32'h13,   32'h80,       32'h0,        0, 4'b1000));
    vecs.push_back(mkVec(0, 0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b00, 1, 32'h13,   32'h0,        32'h00000080, 0, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b01, 0, 32'h11,   32'h0,        32'h0,        1, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b10, 0, 32'h1000, 32'h0,        32'h0,        1, 4'b0000));
    vecs.push_back(mkVec(0, 1, 2'b01, 0, 32'h22,   32'h1234,     32'h0,        0, 4'b1100));
    vecs.push_back(mkVec(0, 0, 2'b01, 0, 32'h22,   32'h0,        32'h00001234, 0, 4'b0000));
    vecs.push_back(mkVec(0, 1, 2'b00, 0, 32'h21,   32'hA5,       32'h0,        0, 4'b0010));
    vecs.push_back(mkVec(0, 0, 2'b01, 1, 32'h20,   32'h0,        32'h0000A500, 0, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b01, 0, 32'h20,   32'h0,        32'hFFFFA500, 0, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b10, 0, 32'h20,   32'h0,        32'h1234A500, 0, 4'b0000));
    vecs.push_back(mkVec(0, 1, 2'b10, 0, 32'h16,   32'hFFFFFFFF, 32'h0,        1, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b10, 0, 32'h14,   32'h0,        32'h0,        0, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b11, 0, 32'h14,   32'h0,        32'h0,        1, 4'b0000));
    vecs.push_back(mkVec(0, 1, 2'b10, 0, 32'hFFC,  32'h55AA55AA, 32'h0,        0, 4'b1111));
    vecs.push_back(mkVec(0, 0, 2'b10, 0, 32'hFFC,  32'h0,        32'h55AA55AA, 0, 4'b0000));
    vecs.push_back(mkVec(0, 1, 2'b10, 0, 32'h1000, 32'h1,        32'h0,        1, 4'b0000));
    vecs.push_back(mkVec(0, 0, 2'b10, 0, 32'h0,    32'h0,        32'h0,        0, 4'b0000));
    vecs.push_back(mkVec(1, 1, 2'b10, 0, 32'h30,   32'hCAFEF00D, 32'h0,        0, 4'b1111));
    vecs.push_back(mkVec(1, 0, 2'b00, 1, 32'h31,   32'h0,        32'h000000F0, 0, 4'b0000));
    vecs.push_back(mkVec(1, 0, 2'b00, 0, 32'h31,   32'h0,        32'hFFFFFFF0, 0, 4'b0000));
    vecs.push_back(mkVec(1, 0, 2'b10, 0, 32'h30,   32'h0,        32'hCAFEF00D, 0, 4'b0000));

    // Reset state with a pending request: nothing may be granted or driven.
    repeat (2) @(negedge clk);
    checkQuiet("reset");
    setReq(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) runVec($sformatf("v%0d", i), vecs[i]);

    // Simultaneous C and D requests.
`ifdef DMEM_CTRL_RR_EN
    expG = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    expG = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    setReq(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    setReq(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk);
      while (!cIf.req_ready && !dIf.req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("arb%0d.granted", k), {31'h0, cIf.req_ready | dIf.req_ready}, 32'h1);
      if (!(cIf.req_ready | dIf.req_ready)) break;
      g = dIf.req_ready;
      check($sformatf("arb%0d.port", k), {31'h0, g}, {31'h0, expG[k]});
      @(posedge clk);
      #1;
      setReq(g, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      n = 0;
      @(negedge clk);
      while (!rspValidOf(g) && n < 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("arb%0d.rdata", k), rdataOf(g), g ? 32'hCAFEF00D : W10);
      if (g) dIf.rsp_ready = 1'b1; else cIf.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      cIf.rsp_ready = 1'b0;
      dIf.rsp_ready = 1'b0;
      if (k < 3) setReq(g, 1'b1, 1'b0, 2'b10, 1'b0, g ? 32'h30 : 32'h10, 32'h0);
    end
    setReq(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    setReq(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    // Response back-pressure: C holds rsp_ready low while D waits.
    applyStimulus("hold", mkVec(0, 0, 2'b10, 0, 32'h10, 32'h0, W10, 0, 4'b0000), ok);
    if (ok) begin
      e = sb.pop_front();
      repeat (2) @(negedge clk);
      setReq(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      for (int c = 0; c < 5; c++) begin
        check($sformatf("hold%0d.valid", c), {31'h0, cIf.rsp_valid}, 32'h1);
        check($sformatf("hold%0d.rdata", c), cIf.rsp_rdata, e.rdata);
        check($sformatf("hold%0d.d_ready", c), {31'h0, dIf.req_ready}, 32'h0);
        @(negedge clk);
      end
      pulseRspReady(1'b0);
      runVec("hold_d", mkVec(1, 0, 2'b10, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, 4'b0000));
    end

    // Reset in the MEM cycle of a store: the store must be abandoned.
    setReq(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11112222);
    n = 0;
    @(negedge clk);
    while (!cIf.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmem.accept", {31'h0, cIf.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    setReq(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rstmem.mem_we", {28'h0, mem_we}, 32'hF);
    #1;
    rst_n = 1'b0;
    #1;
    checkQuiet("rstmem.during");
    @(negedge clk);
    checkQuiet("rstmem.held");
    setReq(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runVec("post_rst40", mkVec(0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 4'b0000));
    runVec("post_rst10", mkVec(0, 0, 2'b10, 0, 32'h10, 32'h0, W10, 0, 4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
